// File: rtl/axi_rd_arbiter_if.sv
// AXI read channel (AR + R) bundle between the read arbiter (master) and the memory side (slave).
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [1:0]            arlock;
  logic [ID_WIDTH-1:0]   arid;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between icache (port 0) and dcache (port 1) refills.
// Optional read watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [15:0]               req_len,
  input  logic [5:0]                req_size,

  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_last,
  output logic [1:0]                rsp_resp,

  output logic                      busy,
  output logic                      timeout_err,

  axi_rd_arbiter_if.master          axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  gnt;
  logic                  any_req;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [7:0]            beat_cnt;
  logic                  ar_hs;
  logic                  beat_hs;
  logic                  to_fire;
  logic                  rready_c;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;

  assign any_req = |req_valid;

  // On a tie the port that did not win last time gets the channel.
  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

  assign sel_addr = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_len  = gnt ? req_len[15:8] : req_len[7:0];
  assign sel_size = gnt ? req_size[5:3] : req_size[2:0];

  assign req_ready = (aresetn && (state == IDLE) && any_req) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  assign ar_hs   = (state == ADDR) && arvalid_q && axi.arready;
  assign beat_hs = (state == DATA) && axi.rvalid && rsp_ready[last_grant] && !to_fire;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arid    = arid_q;
  assign axi.arburst = 2'b01;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arlock  = 2'b00;
  assign axi.rready  = rready_c;

  // last_grant doubles as the owner of the burst in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arid_q     <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= gnt;
            araddr_q   <= sel_addr;
            arlen_q    <= sel_len;
            arsize_q   <= sel_size;
            arid_q     <= ID_WIDTH'(gnt);
            arvalid_q  <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi.rlast) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_RD_TIMEOUT_EN
      if (to_fire) begin
        arvalid_q <= 1'b0;
        state     <= IDLE;
      end
`endif
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;
  logic            drain_q;

  assign to_fire     = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q | to_fire;

  // drain_q swallows R beats of a burst abandoned after its AR was already accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      if ((state == IDLE) || ar_hs || beat_hs || to_fire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_fire) begin
        to_err_q <= 1'b1;
      end
      if (to_fire && ((state == DATA) || ar_hs)) begin
        drain_q <= 1'b1;
      end else if (ar_hs || (drain_q && (state != DATA) && axi.rvalid && axi.rlast)) begin
        drain_q <= 1'b0;
      end
    end
  end
`else
  assign to_fire     = 1'b0;
  // Watchdog compiled out: the flag evaluates to a constant 0 for any legal limit.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  // R beats pass straight through to the owning port; protocol errors are flagged in-line.
  always_comb begin
    rready_c  = 1'b0;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_resp  = 2'b00;
    if (state == DATA) begin
      rready_c              = rsp_ready[last_grant];
      rsp_valid[last_grant] = axi.rvalid;
      rsp_data              = axi.rdata;
      rsp_last              = axi.rlast;
      rsp_resp              = axi.rresp;
      if (beat_hs && ((axi.rid != arid_q) || (axi.rlast && (beat_cnt != arlen_q)))) begin
        rsp_resp = 2'b10;
      end
    end
`ifdef AXI_RD_TIMEOUT_EN
    if (drain_q && (state != DATA)) begin
      rready_c = 1'b1;
    end
    if (to_fire) begin
      rready_c              = 1'b0;
      rsp_valid             = 2'b00;
      rsp_valid[last_grant] = 1'b1;
      rsp_data              = '0;
      rsp_last              = 1'b1;
      rsp_resp              = 2'b11;
    end
`endif
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: grants, round-robin, AR stall, R backpressure, error flags.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int IW = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_len;
  logic [5:0]      req_size;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic [1:0]      rsp_resp;
  logic            busy;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;
  int beats = 0;

  axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  axi_rd_arbiter #(
    .ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_size    (req_size),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_resp    (rsp_resp),
    .busy        (busy),
    .timeout_err (timeout_err),
    .axi         (axi)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic [2:0] s0, input logic [2:0] s1);
    req_valid = rv;
    req_addr  = {a1, a0};
    req_len   = {l1, l0};
    req_size  = {s1, s0};
  endtask

  task automatic grantCycle(input string tag, input logic [1:0] exp_ready);
    #1;
    checkOutput({tag, ".req_ready"}, req_ready, exp_ready);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    tick();
  endtask

  task automatic addrPhase(input string tag, input int stall, input logic [31:0] ea,
                           input logic [7:0] el, input logic [2:0] es, input logic [3:0] eid);
    for (int i = 0; i < stall; i++) begin
      axi.arready = 1'b0;
      #1;
      checkOutput({tag, ".arvalid_hold"}, axi.arvalid, 1'b1);
      checkOutput({tag, ".araddr_hold"}, axi.araddr, ea);
      checkOutput({tag, ".req_ready_quiet"}, req_ready, 2'b00);
      tick();
    end
    axi.arready = 1'b1;
    #1;
    checkOutput({tag, ".arvalid"}, axi.arvalid, 1'b1);
    checkOutput({tag, ".araddr"}, axi.araddr, ea);
    checkOutput({tag, ".arlen"}, axi.arlen, el);
    checkOutput({tag, ".arsize"}, axi.arsize, es);
    checkOutput({tag, ".arid"}, axi.arid, eid);
    checkOutput({tag, ".arburst"}, axi.arburst, 2'b01);
    checkOutput({tag, ".busy"}, busy, 1'b1);
    checkOutput({tag, ".req_ready"}, req_ready, 2'b00);
    tick();
    axi.arready = 1'b0;
    #1;
    checkOutput({tag, ".arvalid_drop"}, axi.arvalid, 1'b0);
  endtask

  task automatic rBeat(input string tag, input logic [1:0] rdy, input logic [127:0] data,
                       input logic last, input logic [3:0] id, input logic [1:0] resp,
                       input logic [1:0] exp_valid, input logic exp_rready, input logic [1:0] exp_resp);
    rsp_ready  = rdy;
    axi.rvalid = 1'b1;
    axi.rdata  = data;
    axi.rlast  = last;
    axi.rid    = id;
    axi.rresp  = resp;
    #1;
    checkOutput({tag, ".rsp_valid"}, rsp_valid, exp_valid);
    checkOutput({tag, ".rready"}, axi.rready, exp_rready);
    checkOutput({tag, ".rsp_data"}, rsp_data, data);
    checkOutput({tag, ".rsp_last"}, rsp_last, last);
    checkOutput({tag, ".rsp_resp"}, rsp_resp, exp_resp);
    if (((rsp_valid & rsp_ready) != 2'b00) && axi.rready) beats++;
    tick();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  initial begin
    aresetn     = 1'b0;
    rsp_ready   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rid     = '0;
    applyStimulus(2'b11, 32'h1111_0000, 32'h2222_0000, 8'd1, 8'd1, 3'd4, 3'd4);
    #3;
    checkOutput("rst.arvalid", axi.arvalid, 1'b0);
    checkOutput("rst.rready", axi.rready, 1'b0);
    checkOutput("rst.req_ready", req_ready, 2'b00);
    checkOutput("rst.rsp_valid", rsp_valid, 2'b00);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.timeout_err", timeout_err, 1'b0);
    checkOutput("rst.araddr", axi.araddr, 32'h0);
    checkOutput("rst.arlen", axi.arlen, 8'h0);
    tick();
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 3'd0, 3'd0);
    aresetn = 1'b1;
    tick();

    $display("[TB] single icache burst");
    applyStimulus(2'b01, 32'h1C00_0000, 32'h0, 8'd3, 8'd0, 3'd4, 3'd0);
    grantCycle("t1_grant", 2'b01);
    applyStimulus(2'b00, 32'h1C00_0000, 32'h0, 8'd3, 8'd0, 3'd4, 3'd0);
    addrPhase("t1_ar", 0, 32'h1C00_0000, 8'd3, 3'd4, 4'd0);
    beats = 0;
    rBeat("t1_b0", 2'b01, 128'hA0, 1'b0, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
    rBeat("t1_b1", 2'b01, 128'hA1, 1'b0, 4'd0, 2'b01, 2'b01, 1'b1, 2'b01);
    rBeat("t1_b2", 2'b01, 128'hA2, 1'b0, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
    rBeat("t1_b3", 2'b01, 128'hA3, 1'b1, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
    #1;
    checkOutput("t1_beats", beats, 4);
    checkOutput("t1_busy_end", busy, 1'b0);
    checkOutput("t1_rsp_valid_end", rsp_valid, 2'b00);

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(2'b10, 32'h0, 32'h2000_0000, 8'd0, 8'd1, 3'd0, 3'd4);
    grantCycle("t2_grant", 2'b10);
    applyStimulus(2'b00, 32'h0, 32'h2000_0000, 8'd0, 8'd1, 3'd0, 3'd4);
    addrPhase("t2_ar", 0, 32'h2000_0000, 8'd1, 3'd4, 4'd1);
    rsp_ready  = 2'b10;
    axi.rvalid = 1'b1;
    axi.rid    = 4'd1;
    #1;
    checkOutput("t2_busy_pre", busy, 1'b1);
    checkOutput("t2_rsp_valid_pre", rsp_valid, 2'b10);
    aresetn = 1'b0;
    #1;
    checkOutput("t2_busy_rst", busy, 1'b0);
    checkOutput("t2_rsp_valid_rst", rsp_valid, 2'b00);
    checkOutput("t2_rready_rst", axi.rready, 1'b0);
    checkOutput("t2_arid_rst", axi.arid, 4'd0);
    checkOutput("t2_araddr_rst", axi.araddr, 32'h0);
    tick();
    axi.rvalid = 1'b0;
    aresetn    = 1'b1;
    tick();

    $display("[TB] simultaneous requests alternate");
    applyStimulus(2'b11, 32'h3000_0000, 32'h4000_0000, 8'd1, 8'd1, 3'd4, 3'd4);
    grantCycle("t3_g0", 2'b01);
    addrPhase("t3_ar0", 0, 32'h3000_0000, 8'd1, 3'd4, 4'd0);
    rBeat("t3_p0b0", 2'b01, 128'hB0, 1'b0, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
    rBeat("t3_p0b1", 2'b01, 128'hB1, 1'b1, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
    grantCycle("t3_g1", 2'b10);
    addrPhase("t3_ar1", 0, 32'h4000_0000, 8'd1, 3'd4, 4'd1);
    rBeat("t3_p1b0", 2'b10, 128'hC0, 1'b0, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    rBeat("t3_p1b1", 2'b10, 128'hC1, 1'b1, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h3000_0100, 32'h4000_0000, 8'd0, 8'd1, 3'd4, 3'd4);
    grantCycle("t3_g2", 2'b01);
    applyStimulus(2'b00, 32'h3000_0100, 32'h4000_0000, 8'd0, 8'd1, 3'd4, 3'd4);
    addrPhase("t3_ar2", 0, 32'h3000_0100, 8'd0, 3'd4, 4'd0);
    rBeat("t3_p0c0", 2'b01, 128'hD0, 1'b1, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);

    $display("[TB] AR stall and response backpressure on port 1");
    applyStimulus(2'b11, 32'h3000_0200, 32'h5000_0000, 8'd0, 8'd3, 3'd4, 3'd4);
    grantCycle("t4_grant", 2'b10);
    addrPhase("t4_ar", 20, 32'h5000_0000, 8'd3, 3'd4, 4'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 3'd0, 3'd0);
    beats = 0;
    rBeat("t4_b0", 2'b10, 128'hE0, 1'b0, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      rBeat("t4_stall", 2'b00, 128'hE1, 1'b0, 4'd1, 2'b00, 2'b10, 1'b0, 2'b00);
    end
    rBeat("t4_b1", 2'b10, 128'hE1, 1'b0, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    rBeat("t4_b2", 2'b10, 128'hE2, 1'b0, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    rBeat("t4_b3", 2'b10, 128'hE3, 1'b1, 4'd1, 2'b00, 2'b10, 1'b1, 2'b00);
    #1;
    checkOutput("t4_beats", beats, 4);
    checkOutput("t4_busy_end", busy, 1'b0);
    checkOutput("t4_timeout_err", timeout_err, 1'b0);

    $display("[TB] rid mismatch and short burst");
    applyStimulus(2'b10, 32'h0, 32'h6000_0000, 8'd0, 8'd3, 3'd0, 3'd4);
    grantCycle("t5_grant", 2'b10);
    applyStimulus(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 3'd0, 3'd0);
    addrPhase("t5_ar", 0, 32'h6000_0000, 8'd3, 3'd4, 4'd1);
    rBeat("t5_badid", 2'b10, 128'hF0, 1'b0, 4'd5, 2'b00, 2'b10, 1'b1, 2'b10);
    rBeat("t5_early_last", 2'b10, 128'hF1, 1'b1, 4'd1, 2'b00, 2'b10, 1'b1, 2'b10);
    #1;
    checkOutput("t5_busy_end", busy, 1'b0);

`ifdef AXI_RD_TIMEOUT_EN
    $display("[TB] read watchdog");
    applyStimulus(2'b01, 32'h7000_0000, 32'h0, 8'd0, 8'd0, 3'd4, 3'd0);
    grantCycle("t6_grant", 2'b01);
    applyStimulus(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 3'd0, 3'd0);
    addrPhase("t6_ar", 0, 32'h7000_0000, 8'd0, 3'd4, 4'd0);
    rsp_ready = 2'b00;
    for (int i = 1; i < 16; i++) begin
      #1;
      checkOutput("t6_wait_err", timeout_err, 1'b0);
      checkOutput("t6_wait_valid", rsp_valid, 2'b00);
      tick();
    end
    #1;
    checkOutput("t6_fire_err", timeout_err, 1'b1);
    checkOutput("t6_fire_valid", rsp_valid, 2'b01);
    checkOutput("t6_fire_last", rsp_last, 1'b1);
    checkOutput("t6_fire_resp", rsp_resp, 2'b11);
    tick();
    #1;
    checkOutput("t6_after_busy", busy, 1'b0);
    checkOutput("t6_after_err", timeout_err, 1'b1);
    checkOutput("t6_after_valid", rsp_valid, 2'b00);
    applyStimulus(2'b01, 32'h7000_0100, 32'h0, 8'd0, 8'd0, 3'd4, 3'd0);
    grantCycle("t6_regrant", 2'b01);
    applyStimulus(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 3'd0, 3'd0);
    addrPhase("t6_ar2", 0, 32'h7000_0100, 8'd0, 3'd4, 4'd0);
    rBeat("t6_b0", 2'b01, 128'h77, 1'b1, 4'd0, 2'b00, 2'b01, 1'b1, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of the core's 128-bit AXI master between two requesters: port 0 = icache refill, port 1 = dcache refill.
- Grants one burst at a time, round-robin. Drives AR from the granted port's latched request and routes R beats back to that port only.
- The write channel is not touched by this block.

Parameters:
- ADDR_WIDTH, 32, address width of AR and request ports.
- AXI_DATA_WIDTH, 128, R data width.
- ID_WIDTH, 4, width of arid/rid.
- TIMEOUT_CYCLES, 1024, watchdog limit. Only used when AXI_RD_TIMEOUT_EN is defined.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accepted.
- req_addr  in  2*ADDR_WIDTH  per-port burst start address; port i in slice i.
- req_len  in  2*8  per-port burst length (beats-1).
- req_size  in  2*3  per-port beat size.
- rsp_valid  out  2  per-port response beat valid.
- rsp_ready  in  2  per-port response beat accept.
- rsp_data  out  AXI_DATA_WIDTH  response data, shared by both ports.
- rsp_last  out  1  last beat of burst.
- rsp_resp  out  2  AXI response code.
- busy  out  1  a burst is in flight.
- timeout_err  out  1  sticky watchdog flag.
- arvalid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arid  out  AXI AR channel.
  - Widths: 1, ADDR_WIDTH, 8, 3, 2, 4, 3, 2, ID_WIDTH.
- arready  in  1.
- rvalid, rdata, rresp, rlast, rid  in  AXI R channel.
  - Widths: 1, AXI_DATA_WIDTH, 2, 1, ID_WIDTH.
- rready  out  1.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All outputs 0: arvalid, rready, req_ready, rsp_valid, busy, timeout_err, AR payload, beat counter.
- Constant AR fields: arburst=2'b01 (INCR), arcache=4'b0000, arprot=3'b000, arlock=2'b00.
- arid = port index zero-extended to ID_WIDTH.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid, grant one port: the only requester, or on a tie the port != last_grant.
  - Pulse req_ready[g] for one cycle; latch addr/len/size; last_grant<=g; go to ADDR.
  - Exactly one req_ready bit is high per grant. No req_ready outside IDLE.
- ADDR:
  - arvalid=1 with latched payload, held stable until arready.
  - On arvalid&&arready go to DATA and clear the beat counter.
  - AR issues the cycle after grant, so the minimum grant-to-AR latency is 1 cycle.
- DATA:
  - rready = rsp_ready[g]; rsp_valid[g] = rvalid; rsp_valid of the other port = 0.
  - rsp_data, rsp_resp, rsp_last follow rdata, rresp, rlast combinationally. Zero-latency pass-through.
  - Each rvalid&&rready beat increments the 8-bit beat counter.
  - On a beat with rlast go to IDLE. The next grant may occur in that following IDLE cycle.
- rid mismatch (rid != arid) on a handshaken beat: rsp_resp forced to 2'b10 (SLVERR) for that beat. Data is still forwarded.
- rlast arriving with beat counter != latched len: rsp_resp forced to 2'b10 on that beat. Return to IDLE anyway.
- Beat counter wraps at 256; arlen max 255 makes this unreachable in legal traffic.
- busy = (state != IDLE).
- A requester dropping req_valid while in ADDR/DATA has no effect. The burst completes and its beats are still offered to that port.
- Reset mid-burst: immediate return to reset values. No recovery of the outstanding transaction; the upstream reset covers the interconnect.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR and DATA and clears on every AR or R handshake.
  - When it reaches TIMEOUT_CYCLES: timeout_err is set (sticky until reset).
  - In the same cycle, one rsp_valid[g] beat is emitted with rsp_last=1 and rsp_resp=2'b11 (DECERR), independent of rsp_ready.
  - arvalid and rready drop and the FSM goes to IDLE. Late R beats after timeout are accepted (rready=1) and discarded until rlast.
- Not defined: no counter; timeout_err tied to 0.

Test Plan:
- Single icache request, addr=0x1C00_0000, len=3: req_ready[0] pulse, then arvalid with araddr=0x1C00_0000, arlen=3, arid=0. After 4 R beats, rsp_valid[0] 4 times with rsp_last on the 4th; busy falls.
- Both ports request in the same cycle after reset: port 0 is granted first, port 1 is granted in the IDLE cycle after port 0's rlast. A third simultaneous pair goes to port 0 again (alternation).
- arready held low 20 cycles: arvalid and araddr stay stable for 20 cycles. No req_ready pulses meanwhile.
- rsp_ready[1]=0 for 5 cycles mid-burst on port 1: rready=0 for those cycles, no beat lost, and the beat count equals len+1.
- rid=5 returned for arid=1: that beat has rsp_resp=2'b10. rlast after 2 beats with len=3: last beat has rsp_resp=2'b10 and the FSM returns to IDLE.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16, rvalid never asserted after AR: at cycle 16 timeout_err=1 and one rsp_valid beat with rsp_resp=2'b11, rsp_last=1; the next request is granted normally.
